// File: rtl/bus_pkg.sv
// Shared types, widths and helpers for the system-bus controller.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        HOLD   = 2'd2,
        ERR    = 2'd3
    } bus_state_t;

    localparam int WAIT_W     = 4;
    localparam int ERR_CNT_W  = 8;
    // Widest packed parameter vector the slicing helper accepts (8 slots x 32 bits).
    localparam int SLOT_VEC_W = 256;

    // Extract field i of width w (w <= 32) from a packed per-slot parameter vector.
    function automatic logic [31:0] slot_field(input logic [SLOT_VEC_W-1:0] vec,
                                               input int i, input int w);
        logic [SLOT_VEC_W-1:0] shifted;
        logic [31:0]           mask;
        shifted = vec >> (i * w);
        mask    = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return shifted[31:0] & mask;
    endfunction

endpackage

// File: rtl/ce_divider.sv
// Free-running CPU clock-enable generator: one-clk pulse every CE_DIV cycles.
module ce_divider #(
    parameter int CE_DIV = 16
) (
    input  logic clk,
    input  logic reset,
    output logic ce
);

    localparam int              CNT_W = (CE_DIV > 2) ? $clog2(CE_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CE_DIV - 1);

    logic [CNT_W-1:0] cnt;

    // Count 0..CE_DIV-1 and pulse ce in the cycle after the terminal count.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            ce  <= 1'b0;
        end else if (cnt == LAST) begin
            cnt <= '0;
            ce  <= 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
            ce  <= 1'b0;
        end
    end

endmodule

// File: rtl/bus_controller.sv
// System-bus controller: address decode, wait-state insertion, CPU hold and error reporting.
module bus_controller
    import bus_pkg::*;
#(
    parameter int                             ADDR_W     = 16,
    parameter int                             NUM_SLAVES = 4,
    parameter logic [NUM_SLAVES*ADDR_W-1:0]   SLAVE_BASE = {16'hF000, 16'h9000, 16'h0000, 16'h0000},
    parameter logic [NUM_SLAVES*ADDR_W-1:0]   SLAVE_MASK = {16'hF000, 16'hF000, 16'h8000, 16'h0000},
    parameter logic [NUM_SLAVES*WAIT_W-1:0]   SLAVE_WAIT = {4'd0, 4'd0, 4'd1, 4'd0},
    parameter int                             CE_DIV     = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     cpu_addr,
    input  logic                  cpu_read,
    input  logic                  cpu_write,
    output logic                  cpu_ready,
    output logic                  cpu_ce,
    output logic [NUM_SLAVES-1:0] slv_cs,
    output logic                  slv_read,
    output logic                  slv_write,
    output logic                  bus_err,
    output logic [ADDR_W-1:0]     err_addr,
    output logic [ERR_CNT_W-1:0]  err_count,
    output logic                  busy
);

    localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    bus_state_t state, state_nxt;

    // Decoder results
    logic              hit;
    logic [SEL_W-1:0]  hit_idx;
    logic [WAIT_W-1:0] hit_wait;
    logic [ADDR_W-1:0] base_i, mask_i;

    // Access context captured when a request is accepted
    logic [SEL_W-1:0]  sel_q;
    logic              dir_write_q;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;
    logic              latch_en;

    // Next values of the registered outputs
    logic [NUM_SLAVES-1:0] cs_nxt;
    logic                  rd_nxt, wr_nxt, rdy_nxt, err_nxt, err_log;

    function automatic logic [NUM_SLAVES-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [NUM_SLAVES-1:0] r;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            r[i] = (idx == SEL_W'(i));
        end
        return r;
    endfunction

    ce_divider #(.CE_DIV(CE_DIV)) u_ce_divider (
        .clk   (clk),
        .reset (reset),
        .ce    (cpu_ce)
    );

    // Priority address decode: scanning downward lets the lowest matching slot win.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        base_i  = '0;
        mask_i  = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            base_i = ADDR_W'(slot_field(SLOT_VEC_W'(SLAVE_BASE), i, ADDR_W));
            mask_i = ADDR_W'(slot_field(SLOT_VEC_W'(SLAVE_MASK), i, ADDR_W));
            if ((mask_i != '0) && ((cpu_addr & mask_i) == base_i)) begin
                hit     = 1'b1;
                hit_idx = SEL_W'(i);
            end
        end
        hit_wait = WAIT_W'(slot_field(SLOT_VEC_W'(SLAVE_WAIT), int'(hit_idx), WAIT_W));
    end

    // Next-state and next-output logic; outputs are registered one edge later.
    always_comb begin
        state_nxt = state;
        cs_nxt    = '0;
        rd_nxt    = 1'b0;
        wr_nxt    = 1'b0;
        rdy_nxt   = 1'b0;
        err_nxt   = 1'b0;
        err_log   = 1'b0;
        latch_en  = 1'b0;
        wait_nxt  = wait_cnt;
        unique case (state)
            IDLE: begin
                if (cpu_read && cpu_write) begin
                    state_nxt = ERR;
                    rdy_nxt   = 1'b1;
                    err_nxt   = 1'b1;
                    err_log   = 1'b1;
                end else if (cpu_read ^ cpu_write) begin
                    if (hit) begin
                        state_nxt = ACCESS;
                        latch_en  = 1'b1;
                        wait_nxt  = hit_wait;
                        cs_nxt    = onehot(hit_idx);
                        rd_nxt    = cpu_read;
                        wr_nxt    = cpu_write;
                    end else begin
                        state_nxt = ERR;
                        rdy_nxt   = 1'b1;
                        err_nxt   = 1'b1;
                        err_log   = 1'b1;
                    end
                end
            end
            ACCESS: begin
                cs_nxt = onehot(sel_q);
                rd_nxt = !dir_write_q;
                wr_nxt = dir_write_q;
                if (wait_cnt == '0) begin
                    state_nxt = HOLD;
                    rdy_nxt   = 1'b1;
                end else begin
                    wait_nxt = wait_cnt - 1'b1;
                end
            end
            HOLD: begin
                if (!cpu_read && !cpu_write) begin
                    state_nxt = IDLE;
                end else begin
                    cs_nxt  = onehot(sel_q);
                    rd_nxt  = !dir_write_q;
                    wr_nxt  = dir_write_q;
                    rdy_nxt = 1'b1;
                end
            end
            ERR: begin
                if (!cpu_read && !cpu_write) begin
                    state_nxt = IDLE;
                end else begin
                    rdy_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and registered outputs; reset clears everything visible to the bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            slv_cs    <= '0;
            slv_read  <= 1'b0;
            slv_write <= 1'b0;
            cpu_ready <= 1'b0;
            bus_err   <= 1'b0;
            busy      <= 1'b0;
            err_addr  <= '0;
            err_count <= '0;
        end else begin
            state     <= state_nxt;
            slv_cs    <= cs_nxt;
            slv_read  <= rd_nxt;
            slv_write <= wr_nxt;
            cpu_ready <= rdy_nxt;
            bus_err   <= err_nxt;
            busy      <= (state_nxt != IDLE);
            if (err_log) begin
                err_addr <= cpu_addr;
                if (err_count != '1) begin
                    err_count <= err_count + 1'b1;
                end
            end
        end
    end

    // Access context: selected slot, direction and wait counter (no reset needed, only read outside IDLE).
    always_ff @(posedge clk) begin
        if (latch_en) begin
            sel_q       <= hit_idx;
            dir_write_q <= cpu_write;
        end
        wait_cnt <= wait_nxt;
    end

endmodule

// File: tb/tb_bus_controller.sv
// Directed self-checking bench for bus_controller.
module tb_bus_controller;
    import bus_pkg::*;

    logic        clk = 1'b0;
    logic        reset, reset2;
    logic [15:0] cpu_addr, cpu_addr2;
    logic        cpu_read, cpu_write, cpu_read2, cpu_write2;

    logic        cpu_ready, cpu_ce, slv_read, slv_write, bus_err, busy;
    logic [3:0]  slv_cs;
    logic [15:0] err_addr;
    logic [7:0]  err_count;

    logic        cpu_ready2, cpu_ce2, slv_read2, slv_write2, bus_err2, busy2;
    logic [3:0]  slv_cs2;
    logic [15:0] err_addr2;
    logic [7:0]  err_count2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bus_controller dut (
        .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_read(cpu_read), .cpu_write(cpu_write),
        .cpu_ready(cpu_ready), .cpu_ce(cpu_ce), .slv_cs(slv_cs), .slv_read(slv_read),
        .slv_write(slv_write), .bus_err(bus_err), .err_addr(err_addr), .err_count(err_count),
        .busy(busy)
    );

    // Second instance: slot 1 (addresses with bit15=0) gets the maximum 15 wait states.
    bus_controller #(.SLAVE_WAIT({4'd0, 4'd0, 4'd15, 4'd0})) dut2 (
        .clk(clk), .reset(reset2), .cpu_addr(cpu_addr2), .cpu_read(cpu_read2), .cpu_write(cpu_write2),
        .cpu_ready(cpu_ready2), .cpu_ce(cpu_ce2), .slv_cs(slv_cs2), .slv_read(slv_read2),
        .slv_write(slv_write2), .bus_err(bus_err2), .err_addr(err_addr2), .err_count(err_count2),
        .busy(busy2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] others;
        reset = 1'b1; cpu_read = 1'b0; cpu_write = 1'b0; cpu_addr = 16'h0000;
        repeat (2) tick();
        others = {cpu_ready, cpu_ce, slv_cs, slv_read, slv_write, bus_err, busy, err_addr, err_count};
        n_checks++;
        if (others !== 32'h0) begin
            n_fail++; $display("FAIL reset_outputs: got %h expected 0", others);
        end
        reset = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            n_checks++;
            if (cpu_ce !== ((k == 16) || (k == 32))) begin
                n_fail++; $display("FAIL cpu_ce cycle %0d: got %b expected %b", k, cpu_ce, (k == 16) || (k == 32));
            end
            others = {cpu_ready, 1'b0, slv_cs, slv_read, slv_write, bus_err, busy, err_addr, err_count};
            n_checks++;
            if (others !== 32'h0) begin
                n_fail++; $display("FAIL idle_outputs cycle %0d: got %h expected 0", k, others);
            end
        end
    endtask

    task automatic test_read_slot1();
        cpu_addr = 16'h0123; cpu_read = 1'b1;
        tick();
        n_checks++;
        if ({slv_cs, slv_read, slv_write, cpu_ready, busy} !== {4'b0010, 1'b1, 1'b0, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL read_c1: got cs=%b rd=%b wr=%b rdy=%b busy=%b expected cs=0010 rd=1 wr=0 rdy=0 busy=1",
                               slv_cs, slv_read, slv_write, cpu_ready, busy);
        end
        tick();
        n_checks++;
        if ({slv_cs, cpu_ready} !== {4'b0010, 1'b0}) begin
            n_fail++; $display("FAIL read_c2: got cs=%b rdy=%b expected cs=0010 rdy=0", slv_cs, cpu_ready);
        end
        tick();
        n_checks++;
        if ({slv_cs, slv_read, cpu_ready} !== {4'b0010, 1'b1, 1'b1}) begin
            n_fail++; $display("FAIL read_c3: got cs=%b rd=%b rdy=%b expected cs=0010 rd=1 rdy=1", slv_cs, slv_read, cpu_ready);
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            n_checks++;
            if ({slv_cs, slv_read, cpu_ready} !== {4'b0010, 1'b1, 1'b1}) begin
                n_fail++; $display("FAIL read_hold %0d: got cs=%b rd=%b rdy=%b expected cs=0010 rd=1 rdy=1",
                                   k, slv_cs, slv_read, cpu_ready);
            end
        end
        cpu_read = 1'b0;
        tick();
        n_checks++;
        if ({slv_cs, slv_read, slv_write, cpu_ready, busy} !== 8'h00) begin
            n_fail++; $display("FAIL read_release: got cs=%b rd=%b wr=%b rdy=%b busy=%b expected all 0",
                               slv_cs, slv_read, slv_write, cpu_ready, busy);
        end
    endtask

    task automatic test_write_slot2();
        cpu_addr = 16'h9004; cpu_write = 1'b1;
        tick();
        n_checks++;
        if ({slv_cs, slv_read, slv_write, cpu_ready} !== {4'b0100, 1'b0, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL write_c1: got cs=%b rd=%b wr=%b rdy=%b expected cs=0100 rd=0 wr=1 rdy=0",
                               slv_cs, slv_read, slv_write, cpu_ready);
        end
        cpu_addr = 16'hF000;
        tick();
        n_checks++;
        if ({slv_cs, slv_write, cpu_ready} !== {4'b0100, 1'b1, 1'b1}) begin
            n_fail++; $display("FAIL write_c2: got cs=%b wr=%b rdy=%b expected cs=0100 wr=1 rdy=1", slv_cs, slv_write, cpu_ready);
        end
        tick();
        n_checks++;
        if (slv_cs !== 4'b0100) begin
            n_fail++; $display("FAIL write_addr_change: got cs=%b expected 0100", slv_cs);
        end
        cpu_write = 1'b0;
        tick();
        n_checks++;
        if ({slv_cs, slv_write, cpu_ready, busy} !== 7'h00) begin
            n_fail++; $display("FAIL write_release: got cs=%b wr=%b rdy=%b busy=%b expected all 0", slv_cs, slv_write, cpu_ready, busy);
        end
    endtask

    task automatic test_read_slot3();
        cpu_addr = 16'hF0AA; cpu_read = 1'b1;
        tick();
        n_checks++;
        if ({slv_cs, cpu_ready} !== {4'b1000, 1'b0}) begin
            n_fail++; $display("FAIL slot3_c1: got cs=%b rdy=%b expected cs=1000 rdy=0", slv_cs, cpu_ready);
        end
        tick();
        n_checks++;
        if ({slv_cs, cpu_ready} !== {4'b1000, 1'b1}) begin
            n_fail++; $display("FAIL slot3_c2: got cs=%b rdy=%b expected cs=1000 rdy=1", slv_cs, cpu_ready);
        end
        cpu_read = 1'b0;
        tick();
    endtask

    task automatic test_unmapped();
        cpu_addr = 16'hA000; cpu_read = 1'b1;
        tick();
        n_checks++;
        if ({bus_err, cpu_ready, slv_cs, slv_read, err_addr, err_count} !== {1'b1, 1'b1, 4'b0000, 1'b0, 16'hA000, 8'd1}) begin
            n_fail++; $display("FAIL unmapped_c1: got err=%b rdy=%b cs=%b rd=%b eaddr=%h ecnt=%0d expected err=1 rdy=1 cs=0000 rd=0 eaddr=a000 ecnt=1",
                               bus_err, cpu_ready, slv_cs, slv_read, err_addr, err_count);
        end
        tick();
        n_checks++;
        if ({bus_err, cpu_ready, busy} !== 3'b011) begin
            n_fail++; $display("FAIL unmapped_c2: got err=%b rdy=%b busy=%b expected err=0 rdy=1 busy=1", bus_err, cpu_ready, busy);
        end
        cpu_read = 1'b0;
        tick();
        n_checks++;
        if ({bus_err, cpu_ready, busy, err_count} !== {3'b000, 8'd1}) begin
            n_fail++; $display("FAIL unmapped_release: got err=%b rdy=%b busy=%b ecnt=%0d expected 0 0 0 1",
                               bus_err, cpu_ready, busy, err_count);
        end
    endtask

    task automatic test_err_saturate();
        for (int k = 0; k < 299; k++) begin
            cpu_addr = 16'hA000 + 16'(k); cpu_read = 1'b1;
            tick();
            cpu_read = 1'b0;
            tick();
        end
        n_checks++;
        if (err_count !== 8'd255) begin
            n_fail++; $display("FAIL err_saturate: got %0d expected 255", err_count);
        end
        n_checks++;
        if (err_addr !== 16'hA12A) begin
            n_fail++; $display("FAIL err_addr_last: got %h expected a12a", err_addr);
        end
    endtask

    task automatic test_protocol_err();
        cpu_addr = 16'h0000; cpu_read = 1'b1; cpu_write = 1'b1;
        tick();
        n_checks++;
        if ({bus_err, cpu_ready, slv_cs, slv_read, slv_write, err_addr, err_count} !==
            {1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 16'h0000, 8'd255}) begin
            n_fail++; $display("FAIL protocol_err: got err=%b rdy=%b cs=%b rd=%b wr=%b eaddr=%h ecnt=%0d expected 1 1 0000 0 0 0000 255",
                               bus_err, cpu_ready, slv_cs, slv_read, slv_write, err_addr, err_count);
        end
        cpu_read = 1'b0; cpu_write = 1'b0;
        tick();
    endtask

    task automatic test_wait15_and_reset();
        reset2 = 1'b1; cpu_read2 = 1'b0; cpu_write2 = 1'b0; cpu_addr2 = 16'h0000;
        repeat (2) tick();
        n_checks++;
        if ({cpu_ce2, cpu_ready2, busy2, err_count2} !== 11'h0) begin
            n_fail++; $display("FAIL dut2_reset: got ce=%b rdy=%b busy=%b ecnt=%0d expected all 0", cpu_ce2, cpu_ready2, busy2, err_count2);
        end
        reset2 = 1'b0;
        // Maximum wait: sample at cycle 0, ready at cycle 17.
        cpu_addr2 = 16'h0100; cpu_read2 = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            tick();
            n_checks++;
            if ({slv_cs2, cpu_ready2} !== {4'b0010, (k == 17)}) begin
                n_fail++; $display("FAIL wait15 cycle %0d: got cs=%b rdy=%b expected cs=0010 rdy=%b", k, slv_cs2, cpu_ready2, k == 17);
            end
        end
        cpu_read2 = 1'b0;
        tick();
        // One error so that the reset below has a nonzero count to clear.
        cpu_addr2 = 16'hA000; cpu_write2 = 1'b1;
        tick();
        n_checks++;
        if ({bus_err2, err_addr2, err_count2} !== {1'b1, 16'hA000, 8'd1}) begin
            n_fail++; $display("FAIL dut2_err: got err=%b eaddr=%h ecnt=%0d expected 1 a000 1", bus_err2, err_addr2, err_count2);
        end
        cpu_write2 = 1'b0;
        tick();
        cpu_addr2 = 16'h0200; cpu_read2 = 1'b1;
        repeat (3) tick();
        n_checks++;
        if ({slv_cs2, busy2, cpu_ready2} !== {4'b0010, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL dut2_in_access: got cs=%b busy=%b rdy=%b expected 0010 1 0", slv_cs2, busy2, cpu_ready2);
        end
        reset2 = 1'b1;
        tick();
        n_checks++;
        if ({slv_cs2, slv_read2, slv_write2, cpu_ready2, busy2, bus_err2, err_count2} !== 17'h0) begin
            n_fail++; $display("FAIL reset_mid_access: got cs=%b rd=%b wr=%b rdy=%b busy=%b err=%b ecnt=%0d expected all 0",
                               slv_cs2, slv_read2, slv_write2, cpu_ready2, busy2, bus_err2, err_count2);
        end
        // Request still held as reset deasserts: accepted on the following edge.
        reset2 = 1'b0;
        tick();
        n_checks++;
        if ({slv_cs2, slv_read2, bus_err2} !== {4'b0010, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL req_after_reset: got cs=%b rd=%b err=%b expected 0010 1 0", slv_cs2, slv_read2, bus_err2);
        end
        cpu_read2 = 1'b0;
        reset2 = 1'b1;
        tick();
    endtask

    initial begin
        reset2 = 1'b1; cpu_read2 = 1'b0; cpu_write2 = 1'b0; cpu_addr2 = 16'h0000;
        test_reset();
        test_read_slot1();
        test_write_slot2();
        test_read_slot3();
        test_unmapped();
        test_err_saturate();
        test_protocol_err();
        test_wait15_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
